// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - two-requester ownership arbiter in front of one SPI master
//
// Purpose: hands exclusive use of a single SPI master to one of two requesters.
// The owner's write/read strobes and transmit byte are passed straight through.
// When the owner releases, the arbiter waits in Drain until the SPI master is idle
// with an empty TX FIFO. Only then does it arbitrate again. Ties are broken
// round-robin using the last served requester.
//
// Optional feature: define SPI_MASTER_ARBITER_TIMEOUT_EN to add an ownership
// watchdog (ParamTimeout_i / Timeout_o).
//
// Ports:
//   Clk_i, Reset_i                  clock, asynchronous active-high reset
//   Req0_i/Req1_i                   ownership requests
//   Gnt0_o/Gnt1_o                   ownership grants
//   Wr0_i/Wr1_i, Rd0_i/Rd1_i        requester write / read-next strobes
//   Data0_i/Data1_i                 requester transmit bytes
//   SPI_Write_o, SPI_ReadNext_o     strobes to the SPI master
//   SPI_Data_o                      transmit byte to the SPI master
//   SPI_Transmission_i              SPI master busy flag
//   SPI_FIFOEmpty_i                 SPI master TX FIFO empty flag
//   Busy_o                          arbiter is not idle
//   ParamTimeout_i                  ownership cycle limit, 0 = unlimited (macro only)
//   Timeout_o                       one-cycle watchdog pulse (macro only)
module spi_master_arbiter #(
    parameter int DataWidth    = 8,
    parameter int TimeoutWidth = 16
) (
    input  logic                    Clk_i,
    input  logic                    Reset_i,
    input  logic                    Req0_i,
    input  logic                    Req1_i,
    output logic                    Gnt0_o,
    output logic                    Gnt1_o,
    input  logic                    Wr0_i,
    input  logic                    Wr1_i,
    input  logic                    Rd0_i,
    input  logic                    Rd1_i,
    input  logic [DataWidth-1:0]    Data0_i,
    input  logic [DataWidth-1:0]    Data1_i,
    output logic                    SPI_Write_o,
    output logic                    SPI_ReadNext_o,
    output logic [DataWidth-1:0]    SPI_Data_o,
    input  logic                    SPI_Transmission_i,
    input  logic                    SPI_FIFOEmpty_i,
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
    input  logic [TimeoutWidth-1:0] ParamTimeout_i,
    output logic                    Timeout_o,
`endif
    output logic                    Busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t state_q, state_d;
    // Last requester served; reset to 1 so requester 0 wins the first tie.
    logic   last_gnt_q, last_gnt_d;

`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
    logic [TimeoutWidth-1:0] cnt_q, cnt_d;
    logic                    timeout_q, timeout_d;
    logic                    expire;

    // A loaded value of zero leaves the counter parked at zero, which disables
    // the watchdog for this ownership.
    assign expire = (cnt_q == TimeoutWidth'(1));
`else
    logic expire;

    assign expire = 1'b0;
`endif

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        cnt_d     = '0;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (Req0_i || Req1_i) begin
                    cnt_d = ParamTimeout_i;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (cnt_q != '0) begin
                    cnt_d     = cnt_q - TimeoutWidth'(1);
                    timeout_d = expire;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign Timeout_o = timeout_q;
`endif

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Req0_i && Req1_i) begin
                    state_d = last_gnt_q ? ST_OWN0 : ST_OWN1;
                end else if (Req0_i) begin
                    state_d = ST_OWN0;
                end else if (Req1_i) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!Req0_i || expire) begin
                    state_d    = ST_DRAIN;
                    last_gnt_d = 1'b0;
                end
            end
            ST_OWN1: begin
                if (!Req1_i || expire) begin
                    state_d    = ST_DRAIN;
                    last_gnt_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!SPI_Transmission_i && SPI_FIFOEmpty_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode from the state register, so an asynchronous reset clears
    // the grants and the pass-through path without waiting for a clock edge.
    always_comb begin
        Gnt0_o         = 1'b0;
        Gnt1_o         = 1'b0;
        SPI_Write_o    = 1'b0;
        SPI_ReadNext_o = 1'b0;
        SPI_Data_o     = '0;
        Busy_o         = (state_q != ST_IDLE);
        if (state_q == ST_OWN0) begin
            Gnt0_o         = 1'b1;
            SPI_Write_o    = Wr0_i;
            SPI_ReadNext_o = Rd0_i;
            SPI_Data_o     = Data0_i;
        end else if (state_q == ST_OWN1) begin
            Gnt1_o         = 1'b1;
            SPI_Write_o    = Wr1_i;
            SPI_ReadNext_o = Rd1_i;
            SPI_Data_o     = Data1_i;
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - self-checking bench for spi_master_arbiter
module tb_spi_master_arbiter;

    logic       Clk_i = 1'b0;
    logic       Reset_i = 1'b1;
    logic       Req0_i = 1'b0, Req1_i = 1'b0;
    logic       Gnt0_o, Gnt1_o;
    logic       Wr0_i = 1'b0, Wr1_i = 1'b0, Rd0_i = 1'b0, Rd1_i = 1'b0;
    logic [7:0] Data0_i = 8'h00, Data1_i = 8'h00;
    logic       SPI_Write_o, SPI_ReadNext_o;
    logic [7:0] SPI_Data_o;
    logic       SPI_Transmission_i = 1'b0, SPI_FIFOEmpty_i = 1'b1;
    logic       Busy_o;
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
    logic [15:0] ParamTimeout_i = 16'd0;
    logic        Timeout_o;
`endif

    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_q[$];

    spi_master_arbiter #(.DataWidth(8), .TimeoutWidth(16)) dut (
        .Clk_i              (Clk_i),
        .Reset_i            (Reset_i),
        .Req0_i             (Req0_i),
        .Req1_i             (Req1_i),
        .Gnt0_o             (Gnt0_o),
        .Gnt1_o             (Gnt1_o),
        .Wr0_i              (Wr0_i),
        .Wr1_i              (Wr1_i),
        .Rd0_i              (Rd0_i),
        .Rd1_i              (Rd1_i),
        .Data0_i            (Data0_i),
        .Data1_i            (Data1_i),
        .SPI_Write_o        (SPI_Write_o),
        .SPI_ReadNext_o     (SPI_ReadNext_o),
        .SPI_Data_o         (SPI_Data_o),
        .SPI_Transmission_i (SPI_Transmission_i),
        .SPI_FIFOEmpty_i    (SPI_FIFOEmpty_i),
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
        .ParamTimeout_i     (ParamTimeout_i),
        .Timeout_o          (Timeout_o),
`endif
        .Busy_o             (Busy_o)
    );

    always #5 Clk_i = ~Clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk_i);
        #2;
    endtask

    // Scoreboard consumer: every SPI write must match the next expected byte.
    always @(negedge Clk_i) begin
        if (SPI_Write_o === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
            else check("spi_data_sb", {24'd0, SPI_Data_o}, {24'd0, exp_q.pop_front()});
        end
    end

    initial begin
        // Reset state
        #1;
        check("rst_gnt0", Gnt0_o, 0);
        check("rst_gnt1", Gnt1_o, 0);
        check("rst_busy", Busy_o, 0);
        check("rst_write", SPI_Write_o, 0);
        check("rst_data", SPI_Data_o, 0);
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
        check("rst_timeout", Timeout_o, 0);
`endif
        tick();
        Reset_i = 1'b0;
        tick();

        // Single request; strobes before grant are dropped
        Req0_i = 1'b1; Wr0_i = 1'b1; Data0_i = 8'h11;
        #1;
        check("pre_gnt_gnt0", Gnt0_o, 0);
        check("pre_gnt_write", SPI_Write_o, 0);
        tick();
        check("gnt0_latency", Gnt0_o, 1);
        check("busy_own0", Busy_o, 1);
        Data0_i = 8'h08; exp_q.push_back(8'h08);
        #1;
        check("own0_write", SPI_Write_o, 1);
        check("own0_data", SPI_Data_o, 8'h08);
        tick();

        // Non-owner strobes discarded
        Wr0_i = 1'b0; Wr1_i = 1'b1; Data1_i = 8'h50; Rd1_i = 1'b1;
        #1;
        check("foreign_write", SPI_Write_o, 0);
        check("foreign_rd", SPI_ReadNext_o, 0);
        check("foreign_data", SPI_Data_o, 8'h08);
        Rd0_i = 1'b1; Data0_i = 8'h33;
        #1;
        check("own0_rd", SPI_ReadNext_o, 1);
        check("own0_data2", SPI_Data_o, 8'h33);
        tick();

        // Release; request 1 raised during ownership must wait
        Wr1_i = 1'b0; Rd1_i = 1'b0; Rd0_i = 1'b0;
        Req0_i = 1'b0; Req1_i = 1'b1;
        tick();
        check("drain_gnt0", Gnt0_o, 0);
        check("drain_gnt1", Gnt1_o, 0);
        check("drain_busy", Busy_o, 1);
        tick();
        check("idle_busy", Busy_o, 0);
        check("idle_gnt1", Gnt1_o, 0);
        tick();
        check("own1_gnt1", Gnt1_o, 1);

        // Write by owner 1, then asynchronous reset mid-ownership
        Wr1_i = 1'b1; Data1_i = 8'hA5; exp_q.push_back(8'hA5);
        #1;
        check("own1_write", SPI_Write_o, 1);
        check("own1_data", SPI_Data_o, 8'hA5);
        #5;
        Reset_i = 1'b1;
        #1;
        check("async_rst_gnt1", Gnt1_o, 0);
        check("async_rst_write", SPI_Write_o, 0);
        check("async_rst_data", SPI_Data_o, 0);
        check("async_rst_busy", Busy_o, 0);
        Wr1_i = 1'b0; Req1_i = 1'b0;
        tick();
        Reset_i = 1'b0;
        tick();

        // Tie after reset: requester 0 first
        Req0_i = 1'b1; Req1_i = 1'b1;
        tick();
        check("tie1_gnt0", Gnt0_o, 1);
        check("tie1_gnt1", Gnt1_o, 0);

        // Drain held by an active transmission
        Req0_i = 1'b0; SPI_Transmission_i = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("drain_hold_busy", Busy_o, 1);
            check("drain_hold_gnt1", Gnt1_o, 0);
            tick();
        end
        SPI_Transmission_i = 1'b0; SPI_FIFOEmpty_i = 1'b0;
        tick();
        check("fifo_hold_busy", Busy_o, 1);
        SPI_FIFOEmpty_i = 1'b1;
        tick();
        check("drain_done_busy", Busy_o, 0);
        check("drain_done_gnt1", Gnt1_o, 0);
        tick();
        check("alt_gnt1", Gnt1_o, 1);

        // Repeat tie: requester 0 served next
        Req1_i = 1'b0; Req0_i = 1'b1;
        tick();
        Req1_i = 1'b1;
        tick();
        check("tie2_idle_gnt0", Gnt0_o, 0);
        check("tie2_idle_gnt1", Gnt1_o, 0);
        tick();
        check("tie2_gnt0", Gnt0_o, 1);
        check("tie2_gnt1", Gnt1_o, 0);
        Req0_i = 1'b0; Req1_i = 1'b0;
        tick();
        tick();
        check("back_idle", Busy_o, 0);

`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
        // Watchdog: 4-cycle limit with requester 1 pending
        ParamTimeout_i = 16'd4; Req0_i = 1'b1;
        tick();
        Req1_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("wd_gnt0", Gnt0_o, 1);
            check("wd_no_pulse", Timeout_o, 0);
            tick();
        end
        check("wd_drain_gnt0", Gnt0_o, 0);
        check("wd_pulse", Timeout_o, 1);
        check("wd_drain_busy", Busy_o, 1);
        ParamTimeout_i = 16'd0;
        tick();
        check("wd_pulse_end", Timeout_o, 0);
        tick();
        check("wd_gnt1_next", Gnt1_o, 1);
        for (int i = 0; i < 6; i++) tick();
        check("wd_disabled_gnt1", Gnt1_o, 1);
        check("wd_disabled_pulse", Timeout_o, 0);
        Req0_i = 1'b0; Req1_i = 1'b0;
        tick();
        tick();
`endif

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/spi_master_arbiter.md
SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 Parameter: DataWidth, 8, width of SPI data words.
REQ-002 Parameter: TimeoutWidth, 16, width of ParamTimeout_i and the ownership watchdog counter.
REQ-003 Port: Clk_i  in  1  single clock; all state changes on rising edge.
REQ-004 Port: Reset_i  in  1  asynchronous, active-high reset.
REQ-005 Port: Req0_i / Req1_i  in  1  ownership request of requester 0/1; held high for a whole transaction.
REQ-006 Port: Gnt0_o / Gnt1_o  out  1  requester 0/1 owns the SPI master.
REQ-007 Port: Wr0_i / Wr1_i  in  1  SPI write strobe of requester 0/1.
REQ-008 Port: Rd0_i / Rd1_i  in  1  SPI read-next strobe of requester 0/1.
REQ-009 Port: Data0_i / Data1_i  in  DataWidth  transmit byte of requester 0/1.
REQ-010 Port: SPI_Write_o, SPI_ReadNext_o  out  1  strobes to SPI master.
REQ-011 Port: SPI_Data_o  out  DataWidth  transmit byte to SPI master.
REQ-012 Port: SPI_Transmission_i, SPI_FIFOEmpty_i  in  1  SPI master busy and TX-FIFO-empty flags.
REQ-013 Port: Busy_o  out  1  arbiter not in Idle.
REQ-014 Port (macro only): ParamTimeout_i  in  TimeoutWidth  ownership cycle limit; Timeout_o  out  1  watchdog fired.

Function
REQ-015 States SHALL be Idle, Own0, Own1, Drain; GntN_o SHALL be 1 exactly while in OwnN, decoded from the state register.
REQ-016 Idle: Req0 only -> Own0; Req1 only -> Own1; both -> requester not served last (LastGnt register); neither -> stay.
REQ-017 Grant latency SHALL be one cycle: Req high before edge n -> Gnt high after edge n.
REQ-018 In OwnN, SPI_Write_o/SPI_ReadNext_o/SPI_Data_o SHALL equal WrN_i/RdN_i/DataN_i combinationally; the other requester's strobes SHALL be discarded.
REQ-019 Outside Own0/Own1, SPI_Write_o and SPI_ReadNext_o SHALL be 0 and SPI_Data_o all zeros.
REQ-020 OwnN with ReqN_i=0 -> Drain; LastGnt updated to N on leaving OwnN.
REQ-021 Drain -> Idle only when SPI_Transmission_i=0 and SPI_FIFOEmpty_i=1 in the same cycle; otherwise stay.
REQ-022 Requests raised during OwnX or Drain SHALL wait; arbitration occurs only in Idle, at least one Idle cycle between owners.
REQ-023 Busy_o SHALL be 1 in Own0, Own1, Drain.
REQ-024 Strobes asserted by a requester before its Gnt is high SHALL be dropped, not queued.

Reset
REQ-025 Reset_i=1 SHALL immediately force Idle, Gnt0_o=Gnt1_o=0, Busy_o=0, SPI strobes 0, SPI_Data_o 0, LastGnt=1 (requester 0 wins first tie), Timeout_o=0, counter 0.
REQ-026 Reset mid-ownership SHALL drop grants without a Drain phase; after release arbitration restarts from Idle.

Configuration
REQ-027 Macro SPI_MASTER_ARBITER_TIMEOUT_EN defined: ParamTimeout_i/Timeout_o exist; counter loads ParamTimeout_i on entering OwnN, decrements each OwnN cycle; reaching 0 in OwnN forces Drain, Timeout_o pulses 1 cycle, LastGnt=N; ParamTimeout_i=0 disables the watchdog.
REQ-028 Macro undefined: ports, counter and Timeout_o absent; ownership unbounded.
REQ-029 Timed-out requester still holding ReqN_i SHALL be treated as a fresh request in Idle, subject to LastGnt priority.

Verification
REQ-030 Reset, Req0=1 -> Gnt0=1 next cycle; Wr0=1, Data0=0x08 -> SPI_Write_o=1, SPI_Data_o=0x08 same cycle.
REQ-031 Req0=Req1=1 from Idle after reset -> Gnt0 first; Req0 drops, drain done -> Gnt1 follows; repeat tie -> Gnt0 (alternation).
REQ-032 Owner releases with SPI_Transmission_i=1 for 5 cycles -> Busy_o=1, no grant until cycle transmission=0 and FIFOEmpty=1, then Idle.
REQ-033 Gnt0=1, Wr1=1, Data1=0x50 -> SPI_Write_o and SPI_Data_o unaffected by requester 1.
REQ-034 Reset_i asserted mid-Own1 -> Gnt1_o=0 and strobes 0 without waiting for a clock edge.
REQ-035 Macro defined, ParamTimeout_i=4, Req0 held -> Gnt0 high 4 cycles, Timeout_o 1-cycle pulse, Drain; Req1 pending -> Gnt1 next.
